// File: rtl/sync_fifo_flags_if.sv
// Handshake/data/status bundle for sync_fifo_flags.
// master = producer/consumer side, slave = the FIFO itself.
interface sync_fifo_flags_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_in;
  logic             write;
  logic             read;
  logic             clear_err;
  logic [WIDTH-1:0] data_out;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_almost_full;
  logic             fifo_almost_empty;
  logic [CW-1:0]    fifo_count;
  logic             overflow;
  logic             underflow;

  modport master (
    output data_in, write, read, clear_err,
    input  data_out, fifo_full, fifo_empty, fifo_almost_full,
           fifo_almost_empty, fifo_count, overflow, underflow
  );

  modport slave (
    input  data_in, write, read, clear_err,
    output data_out, fifo_full, fifo_empty, fifo_almost_full,
           fifo_almost_empty, fifo_count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with arbitrary depth, occupancy count, almost flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output instead of registered read.
module sync_fifo_flags #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  sync_fifo_flags_if.slave bus
);
  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  if (WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_flags: WIDTH must be >= 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_flags: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_flags: AE_LEVEL out of range 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             full, empty, wr_acc, rd_acc;

  // Explicit wrap so non-power-of-2 depths never index past DEPTH-1.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign wr_acc = bus.write && !full;
  assign rd_acc = bus.read && !empty;

  always_comb begin
    wr_ptr_d    = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = rd_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d     = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A fresh error event outranks clear_err in the same cycle.
    overflow_d  = (bus.write && full)  ? 1'b1 : (bus.clear_err ? 1'b0 : overflow_q);
    underflow_d = (bus.read  && empty) ? 1'b1 : (bus.clear_err ? 1'b0 : underflow_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.data_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.data_out = mem_q[rd_ptr_q];
`else
  logic [WIDTH-1:0] data_out_q, data_out_d;

  always_comb begin
    data_out_d = rd_acc ? mem_q[rd_ptr_q] : data_out_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_out_q <= '0;
    else     data_out_q <= data_out_d;
  end

  assign bus.data_out = data_out_q;
`endif

  assign bus.fifo_count        = count_q;
  assign bus.fifo_full         = full;
  assign bus.fifo_empty        = empty;
  assign bus.fifo_almost_full  = (count_q >= CW'(AF_LEVEL));
  assign bus.fifo_almost_empty = (count_q <= CW'(AE_LEVEL));
  assign bus.overflow          = overflow_q;
  assign bus.underflow         = underflow_q;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: DEPTH=8 default instance plus a DEPTH=5 instance.
module tb_sync_fifo_flags;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_flags_if #(.WIDTH(8), .DEPTH(8)) bus8 ();
  sync_fifo_flags_if #(.WIDTH(8), .DEPTH(5)) bus5 ();

  sync_fifo_flags #(.WIDTH(8), .DEPTH(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  sync_fifo_flags #(.WIDTH(8), .DEPTH(5)) u_dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5.slave)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] q5 [$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock of stimulus on the DEPTH=8 instance; outputs sampled 1ns after the edge.
  task automatic cyc8(input bit w, input bit r, input bit ce, input logic [7:0] d);
    bus8.write = w; bus8.read = r; bus8.clear_err = ce; bus8.data_in = d;
    @(posedge clk); #1;
    bus8.write = 1'b0; bus8.read = 1'b0; bus8.clear_err = 1'b0;
  endtask

  // DEPTH=5 op with a reference queue tracking expected contents.
  task automatic op5(input bit w, input bit r, input logic [7:0] d);
    bit racc, wacc;
    logic [7:0] exp;
    exp  = '0;
    racc = r && (q5.size() > 0);
    wacc = w && (q5.size() < 5);
`ifdef SYNC_FIFO_FWFT_EN
    if (racc) chk("d5_fwft", bus5.data_out, q5[0]);
`endif
    if (racc) exp = q5.pop_front();
    if (wacc) q5.push_back(d);
    bus5.write = w; bus5.read = r; bus5.clear_err = 1'b0; bus5.data_in = d;
    @(posedge clk); #1;
    bus5.write = 1'b0; bus5.read = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
    if (racc) chk("d5_data", bus5.data_out, exp);
`endif
    chk("d5_count", bus5.fifo_count, q5.size());
    chk("d5_full", bus5.fifo_full, q5.size() == 5);
  endtask

  initial begin
    bus8.write = 0; bus8.read = 0; bus8.clear_err = 0; bus8.data_in = '0;
    bus5.write = 0; bus5.read = 0; bus5.clear_err = 0; bus5.data_in = '0;

    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_empty", bus8.fifo_empty, 1);
    chk("rst_full", bus8.fifo_full, 0);
    chk("rst_count", bus8.fifo_count, 0);
    chk("rst_ae", bus8.fifo_almost_empty, 1);
    chk("rst_af", bus8.fifo_almost_full, 0);
    chk("rst_ovf", bus8.overflow, 0);
    chk("rst_udf", bus8.underflow, 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst_dout", bus8.data_out, 8'h00);
`endif
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Fill: almost_full from count 6, almost_empty up to count 2
    for (int i = 0; i < 8; i++) begin
      cyc8(1, 0, 0, 8'(8'h10 + i));
      chk("fill_count", bus8.fifo_count, i + 1);
      chk("fill_af", bus8.fifo_almost_full, (i + 1) >= 6);
      chk("fill_ae", bus8.fifo_almost_empty, (i + 1) <= 2);
    end
    chk("fill_full", bus8.fifo_full, 1);

    // Write while full is dropped and flagged
    cyc8(1, 0, 0, 8'hAA);
    chk("ovf_set", bus8.overflow, 1);
    chk("ovf_count", bus8.fifo_count, 8);

    // Drain in order
    for (int i = 0; i < 8; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      chk("drain_fwft", bus8.data_out, 8'(8'h10 + i));
`endif
      cyc8(0, 1, 0, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
      chk("drain_data", bus8.data_out, 8'(8'h10 + i));
`endif
      chk("drain_count", bus8.fifo_count, 7 - i);
    end
    chk("drain_empty", bus8.fifo_empty, 1);

    // Read while empty
    cyc8(0, 1, 0, 8'h00);
    chk("udf_set", bus8.underflow, 1);
    chk("udf_count", bus8.fifo_count, 0);
    chk("ovf_sticky", bus8.overflow, 1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("udf_dout_hold", bus8.data_out, 8'h17);
`endif
    cyc8(0, 0, 1, 8'h00);
    chk("clr_ovf", bus8.overflow, 0);
    chk("clr_udf", bus8.underflow, 0);

    // clear_err together with a new underflow: set wins
    cyc8(0, 1, 1, 8'h00);
    chk("setwins_udf", bus8.underflow, 1);
    cyc8(0, 0, 1, 8'h00);
    chk("setwins_clr", bus8.underflow, 0);

    // Read+write at empty: write lands, read rejected, no write-through
    cyc8(1, 1, 0, 8'h20);
    chk("rw_empty_count", bus8.fifo_count, 1);
    chk("rw_empty_udf", bus8.underflow, 1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rw_empty_dout", bus8.data_out, 8'h17);
`endif
    cyc8(0, 0, 1, 8'h00);
    cyc8(1, 0, 0, 8'h21);
    cyc8(1, 0, 0, 8'h22);
    chk("rw_pre_count", bus8.fifo_count, 3);

    // 20 simultaneous read+write cycles, crossing the pointer wrap
    for (int i = 0; i < 20; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      chk("rw_fwft", bus8.data_out, 8'(8'h20 + i));
`endif
      cyc8(1, 1, 0, 8'(8'h23 + i));
`ifndef SYNC_FIFO_FWFT_EN
      chk("rw_data", bus8.data_out, 8'(8'h20 + i));
`endif
      chk("rw_count", bus8.fifo_count, 3);
    end
    chk("rw_no_err", bus8.overflow | bus8.underflow, 0);

    // Remaining 0x34,0x35,0x36; top up to full then read+write at full
    for (int i = 0; i < 5; i++) cyc8(1, 0, 0, 8'(8'h40 + i));
    chk("top_full", bus8.fifo_full, 1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("rwfull_fwft", bus8.data_out, 8'h34);
`endif
    cyc8(1, 1, 0, 8'hBB);
    chk("rwfull_count", bus8.fifo_count, 7);
    chk("rwfull_ovf", bus8.overflow, 1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rwfull_data", bus8.data_out, 8'h34);
`endif

    // Reset mid-operation discards everything immediately
    @(negedge clk); rst = 1'b1; #1;
    chk("rst2_count", bus8.fifo_count, 0);
    chk("rst2_empty", bus8.fifo_empty, 1);
    chk("rst2_ovf", bus8.overflow, 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst2_dout", bus8.data_out, 8'h00);
`endif
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

`ifdef SYNC_FIFO_FWFT_EN
    cyc8(1, 0, 0, 8'h3C);
    chk("fwft_show", bus8.data_out, 8'h3C);
    chk("fwft_nempty", bus8.fifo_empty, 0);
    cyc8(0, 1, 0, 8'h00);
    chk("fwft_pop_empty", bus8.fifo_empty, 1);
`endif

    // DEPTH=5: bursts with wrap, full at 5, rejected write while full
    begin
      logic [1:0] ops [26];
      int k;
      ops = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01,
              2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01, 2'b11,
              2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b10};
      k = 0;
      foreach (ops[i]) begin
        op5(ops[i][0], ops[i][1], 8'(8'h50 + k));
        if (ops[i][0]) k++;
      end
      chk("d5_ovf", bus5.overflow, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Parametrised synchronous single-clock FIFO. Next generation of the team's basic FIFO.
- Adds the following over the basic FIFO:
  - true full/empty tracking at exactly DEPTH entries
  - arbitrary (non-power-of-2) depth
  - occupancy count
  - programmable almost-full/almost-empty flags
  - sticky overflow/underflow error flags
  - asynchronous reset
- Sits between producer/consumer datapath stages as an elastic buffer.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 8, number of storage entries (>=2, any integer)
AF_LEVEL, DEPTH-2, fifo_almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, fifo_almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
data_in  input  WIDTH  write data
write  input  1  write request
read  input  1  read request
clear_err  input  1  synchronous clear of overflow/underflow
data_out  output  WIDTH  read data (registered)
fifo_full  output  1  count == DEPTH
fifo_empty  output  1  count == 0
fifo_almost_full  output  1  count >= AF_LEVEL
fifo_almost_empty  output  1  count <= AE_LEVEL
fifo_count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset is asynchronous and active-high:
  - clears both pointers and count; data_out=0; overflow=underflow=0.
  - Resulting flags: fifo_empty=1, fifo_full=0, fifo_almost_empty=1, fifo_almost_full=(AF_LEVEL==0 ? 1 : 0), which is 0 for legal AF_LEVEL.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data immediately; no partial transfer completes.
- Pointers:
  - width $clog2(DEPTH), minimum 1.
  - Increment modulo DEPTH: wrap from DEPTH-1 to 0 explicitly, not by binary rollover.
- Accepted operations:
  - Write accepted = write && !fifo_full. Accepted write stores data_in at wr_ptr and advances wr_ptr.
  - Read accepted = read && !fifo_empty. Accepted read advances rd_ptr and loads data_out <= mem[rd_ptr].
- data_out:
  - Read latency is 1 cycle: data valid the cycle after read accepted.
  - Holds its value when no read is accepted.
- Count update (per cycle):
  - write only: +1
  - read only: -1
  - both or neither: unchanged
- All flags are derived combinationally from registered count. No flag glitching between pointer and count.
- Simultaneous read+write:
  - Empty: write accepted, read rejected (underflow set); count 0->1. No write-through to data_out.
  - Full: read accepted, write rejected (overflow set); count DEPTH->DEPTH-1.
  - Otherwise: both accepted, count unchanged.
- Error flags:
  - overflow set on write && fifo_full; underflow set on read && fifo_empty.
  - Both remain set until clear_err or rst.
  - clear_err in the same cycle as a new error event: the set wins.
- Rejected operations never modify memory, pointers, count or data_out.
- Illegal parameters (DEPTH<2, WIDTH<1, AF/AE out of range) raise $error at elaboration.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - data_out continuously presents mem[rd_ptr] whenever fifo_empty=0. Zero read latency.
  - read acknowledges and pops the current word.
  - Next word appears the cycle after pop, or stays invalid if the FIFO becomes empty.
  - data_out is don't-care while empty.
  - All flags and count behave as in standard mode.
- Undefined: standard registered-read mode as described above.

Test Plan:
- Reset with defaults (WIDTH=8, DEPTH=8):
  - Stimulus: rst pulsed mid-cycle without a clock edge.
  - Expected: immediately fifo_empty=1, fifo_count=0, data_out=0x00, overflow=0.
- Fill then drain:
  - Stimulus: write 0x10..0x17 on 8 consecutive cycles.
  - Expected: fifo_full=1, count=8, almost_full rose at count 6.
  - Then: 8 reads return 0x10..0x17 in order, each 1 cycle after its read; empty=1 after the last read.
- Overflow/underflow:
  - Stimulus: write 0xAA while full.
  - Expected: overflow=1, count stays 8, 0xAA is never read out.
  - Stimulus: read while empty.
  - Expected: underflow=1, data_out unchanged.
  - Stimulus: clear_err.
  - Expected: both flags clear next cycle.
- Simultaneous read+write:
  - Stimulus: count=3 with read+write each cycle for 20 cycles.
  - Expected: count stays 3, order preserved across pointer wrap.
  - Stimulus: read+write at full.
  - Expected: count 8->7, overflow=1.
- Non-power-of-2 depth (DEPTH=5):
  - Stimulus: 12 write/read pairs with interleaved bursts.
  - Expected: pointers wrap 4->0, full asserts at count 5, data integrity matches a reference queue.
- FWFT build (SYNC_FIFO_FWFT_EN defined):
  - Stimulus: write 0x3C into empty FIFO.
  - Expected: data_out=0x3C the cycle after the write with no read issued; a read pops it and sets empty=1.
